bfmem_arbiter: RTL and testbench

- Shares one single-port program/data SRAM between three requesters:
  - the CPU instruction-fetch port (i_*);
  - the CPU data port (d_*);
  - a host loader/debug port (l_*).
- Arbitrates round-robin and runs one memory transaction at a time with a fixed read latency.
- Returns results to each requester over the same four-phase req/ack handshake the CPU ports already use.
- Sits between bfcpu-style cores and the unified memory macro.

---
 rtl/bfmem_pkg.sv | 34 +++
 rtl/rr_arbiter3.sv | 37 +++
 rtl/bfmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_bfmem_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfmem_pkg.sv
// Shared types and constants for the bfmem arbiter: FSM encoding, port
// indices, transfer directions and small index helpers.
package bfmem_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Port indices; also the bit positions inside gnt
  localparam logic [1:0] PORT_L = 2'd0;
  localparam logic [1:0] PORT_D = 2'd1;
  localparam logic [1:0] PORT_I = 2'd2;

  // Transfer direction, same encoding as the CPU's dir signal
  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  // Reduce a small value (0..5) modulo 3
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // Index of the set bit in a one-hot 3-bit vector (0 when empty)
  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    if (oh[2]) return 2'd2;
    if (oh[1]) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin picker. The search starts at the port
// after 'last' and the first requesting port in that order wins.
module rr_arbiter3
  import bfmem_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt
);

  logic [1:0] first;
  logic [2:0] req_rot;
  logic [2:0] gnt_rot;

  // Highest-priority port this round
  assign first = wrap3({1'b0, last} + 3'd1);

  // Rotate requests so that bit 0 is the highest-priority port
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rot
      assign req_rot[gi] = req[wrap3({1'b0, first} + 3'(gi))];
    end
  endgenerate

  // Fixed-priority pick on the rotated vector (lowest bit wins)
  assign gnt_rot[0] = req_rot[0];
  assign gnt_rot[1] = req_rot[1] & ~req_rot[0];
  assign gnt_rot[2] = req_rot[2] & ~req_rot[1] & ~req_rot[0];

  // Rotate the one-hot grant back to port numbering
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_unrot
      assign gnt[gi] = gnt_rot[wrap3(3'(gi) + 3'd3 - {1'b0, first})];
    end
  endgenerate

endmodule

// File: rtl/bfmem_arbiter.sv
// Shares one single-port SRAM between CPU fetch, CPU data and a host loader.
// One transaction at a time, round-robin arbitration, fixed read latency and
// a four-phase req/ack handshake back to each requester.
module bfmem_arbiter
  import bfmem_pkg::*;
#(
  parameter int i_addr_width   = 16,
  parameter int d_addr_width   = 8,
  parameter int mem_addr_width = 17,
  parameter int mem_latency    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic [i_addr_width-1:0]   i_addr,
  output logic                      i_ack,
  output logic [7:0]                i_rdata,
  input  logic                      d_req,
  input  logic                      d_dir,
  input  logic [d_addr_width-1:0]   d_addr,
  input  logic [7:0]                d_wdata,
  output logic                      d_ack,
  output logic [7:0]                d_rdata,
  input  logic                      l_req,
  input  logic                      l_dir,
  input  logic [mem_addr_width-1:0] l_addr,
  input  logic [7:0]                l_wdata,
  output logic                      l_ack,
  output logic [7:0]                l_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [mem_addr_width-1:0] mem_addr,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata,
  output logic [2:0]                gnt
);

  // Latency counter start value: WAIT ends when the counter is zero
  localparam logic [1:0] LAT_LOAD = 2'(mem_latency - 1);

  state_t                    state_reg, state_next;
  logic [2:0]                req_vec;
  logic [2:0]                pick;
  logic [2:0]                own_reg;
  logic [1:0]                last_reg;
  logic [1:0]                cnt_reg;
  logic [mem_addr_width-1:0] addr_reg;
  logic                      we_reg;
  logic [7:0]                wdata_reg;
  logic                      own_req;
  logic                      rd_done;
  logic [mem_addr_width-1:0] i_map;
  logic [mem_addr_width-1:0] d_map;
  logic [2:0]                ack_vec;

  // Bit order matches gnt: bit0 loader, bit1 data, bit2 fetch
  assign req_vec = {i_req, d_req, l_req};
  assign own_req = |(own_reg & req_vec);
  assign rd_done = (state_reg == ST_WAIT) && (cnt_reg == 2'd0);

  // Fetch occupies the lower half of memory, data the upper half
  assign i_map = {1'b0, (mem_addr_width-1)'(i_addr)};
  assign d_map = {1'b1, (mem_addr_width-1)'(d_addr)};

  rr_arbiter3 u_rr (
    .req  (req_vec),
    .last (last_reg),
    .gnt  (pick)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state; a requester that has already released skips ACK
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req_vec) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (we_reg == DIR_WRITE) state_next = own_req ? ST_ACK : ST_IDLE;
        else                     state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_reg == 2'd0) state_next = own_req ? ST_ACK : ST_IDLE;
      end
      ST_ACK: begin
        if (!own_req) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Grant: latch owner, round-robin pointer and the winner's request fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_reg   <= 3'b000;
      last_reg  <= PORT_I;
      addr_reg  <= '0;
      we_reg    <= DIR_READ;
      wdata_reg <= 8'h00;
    end else if ((state_reg == ST_IDLE) && (|req_vec)) begin
      own_reg  <= pick;
      last_reg <= onehot_idx(pick);
      if (pick[PORT_L]) begin
        addr_reg  <= l_addr;
        we_reg    <= l_dir;
        wdata_reg <= l_wdata;
      end else if (pick[PORT_D]) begin
        addr_reg  <= d_map;
        we_reg    <= d_dir;
        wdata_reg <= d_wdata;
      end else begin
        addr_reg  <= i_map;
        we_reg    <= DIR_READ;
        wdata_reg <= 8'h00;
      end
    end
  end

  // Read latency counter: loaded on a read issue, counts down in WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 2'd0;
    end else if ((state_reg == ST_ISSUE) && (we_reg == DIR_READ)) begin
      cnt_reg <= LAT_LOAD;
    end else if ((state_reg == ST_WAIT) && (cnt_reg != 2'd0)) begin
      cnt_reg <= cnt_reg - 2'd1;
    end
  end

  // Per-port read data holding registers and ack decode
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_port
      logic [7:0] rdata_reg;

      // Capture memory data for the owner; held until its next read completes
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                         rdata_reg <= 8'h00;
        else if (rd_done && own_reg[gi]) rdata_reg <= mem_rdata;
      end

      assign ack_vec[gi] = (state_reg == ST_ACK) && own_reg[gi];
    end
  endgenerate

  assign l_ack   = ack_vec[0];
  assign d_ack   = ack_vec[1];
  assign i_ack   = ack_vec[2];
  assign l_rdata = g_port[0].rdata_reg;
  assign d_rdata = g_port[1].rdata_reg;
  assign i_rdata = g_port[2].rdata_reg;

  // Memory strobe and ownership are pure decodes of registered state
  assign mem_en    = (state_reg == ST_ISSUE);
  assign mem_we    = mem_en && (we_reg == DIR_WRITE);
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign gnt       = (state_reg != ST_IDLE) ? own_reg : 3'b000;

endmodule

// File: tb/tb_bfmem_arbiter.sv
// Scoreboard bench for bfmem_arbiter: stimulus pushes expected memory strobes
// and acks; a negedge monitor pops and compares as the DUT presents them.
module tb_bfmem_arbiter;
  import bfmem_pkg::*;

  typedef struct {
    logic [16:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [2:0]  gnt;
    int          cyc;
  } mem_exp_t;

  typedef struct {
    int         port;
    logic [7:0] rdata;
    int         cyc;
  } ack_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mem_exp_t mem_q[$];
  ack_exp_t ack_q[$];

  // DUT with mem_latency = 1
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_ack;
  logic [7:0]  i_rdata;
  logic        d_req = 1'b0;
  logic        d_dir = 1'b0;
  logic [7:0]  d_addr = '0;
  logic [7:0]  d_wdata = '0;
  logic        d_ack;
  logic [7:0]  d_rdata;
  logic        l_req = 1'b0;
  logic        l_dir = 1'b0;
  logic [16:0] l_addr = '0;
  logic [7:0]  l_wdata = '0;
  logic        l_ack;
  logic [7:0]  l_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [2:0]  gnt;

  // DUT with mem_latency = 4 (fetch port only)
  logic        x_i_req = 1'b0;
  logic [15:0] x_i_addr = '0;
  logic        x_i_ack;
  logic [7:0]  x_i_rdata;
  logic        x_d_req = 1'b0;
  logic        x_d_dir = 1'b0;
  logic [7:0]  x_d_addr = '0;
  logic [7:0]  x_d_wdata = '0;
  logic        x_d_ack;
  logic [7:0]  x_d_rdata;
  logic        x_l_req = 1'b0;
  logic        x_l_dir = 1'b0;
  logic [16:0] x_l_addr = '0;
  logic [7:0]  x_l_wdata = '0;
  logic        x_l_ack;
  logic [7:0]  x_l_rdata;
  logic        x_mem_en;
  logic        x_mem_we;
  logic [16:0] x_mem_addr;
  logic [7:0]  x_mem_wdata;
  logic [7:0]  x_mem_rdata;
  logic [2:0]  x_gnt;

  bfmem_arbiter #(.i_addr_width(16), .d_addr_width(8), .mem_addr_width(17), .mem_latency(1)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .l_req(l_req), .l_dir(l_dir), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .gnt(gnt)
  );

  bfmem_arbiter #(.i_addr_width(16), .d_addr_width(8), .mem_addr_width(17), .mem_latency(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .i_req(x_i_req), .i_addr(x_i_addr), .i_ack(x_i_ack), .i_rdata(x_i_rdata),
    .d_req(x_d_req), .d_dir(x_d_dir), .d_addr(x_d_addr), .d_wdata(x_d_wdata), .d_ack(x_d_ack), .d_rdata(x_d_rdata),
    .l_req(x_l_req), .l_dir(x_l_dir), .l_addr(x_l_addr), .l_wdata(x_l_wdata), .l_ack(x_l_ack), .l_rdata(x_l_rdata),
    .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata), .mem_rdata(x_mem_rdata),
    .gnt(x_gnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: fixed preload table plus a written-location overlay
  bit         wr_valid [0:131071];
  logic [7:0] wr_data  [0:131071];

  function automatic logic [7:0] mem_read(input logic [16:0] a);
    if (wr_valid[a]) return wr_data[a];
    case (a)
      17'h00012: return 8'h2B;
      17'h00100: return 8'h91;
      17'h10040: return 8'hC4;
      17'h10007: return 8'h19;
      17'h1ABCD: return 8'h77;
      17'h1ABCE: return 8'h5A;
      default:   return 8'h00;
    endcase
  endfunction

  logic [7:0] rd1 = 8'hEE;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_valid[mem_addr] <= 1'b1;
      wr_data[mem_addr]  <= mem_wdata;
    end
    rd1 <= (mem_en && !mem_we) ? mem_read(mem_addr) : 8'hEE;
  end
  assign mem_rdata = rd1;

  logic [7:0] p4 [4];
  always @(posedge clk) begin
    p4[0] <= (x_mem_en && !x_mem_we) ? mem_read(x_mem_addr) : 8'hEE;
    p4[1] <= p4[0];
    p4[2] <= p4[1];
    p4[3] <= p4[2];
  end
  assign x_mem_rdata = p4[3];

  function automatic logic ack_of(input int p);
    case (p)
      0:       return l_ack;
      1:       return d_ack;
      default: return i_ack;
    endcase
  endfunction

  function automatic logic [7:0] rdata_of(input int p);
    case (p)
      0:       return l_rdata;
      1:       return d_rdata;
      default: return i_rdata;
    endcase
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_i_ack"}, 32'(i_ack), 0);
    check_eq({tag, "_d_ack"}, 32'(d_ack), 0);
    check_eq({tag, "_l_ack"}, 32'(l_ack), 0);
    check_eq({tag, "_i_rdata"}, 32'(i_rdata), 0);
    check_eq({tag, "_d_rdata"}, 32'(d_rdata), 0);
    check_eq({tag, "_l_rdata"}, 32'(l_rdata), 0);
    check_eq({tag, "_mem_en"}, 32'(mem_en), 0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check_eq({tag, "_gnt"}, 32'(gnt), 0);
  endtask

  task automatic push_exp(input int p, input logic dir, input logic [16:0] maddr, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input int mem_cyc, input int ack_cyc);
    mem_exp_t me;
    ack_exp_t ae;
    me.addr = maddr; me.we = dir; me.wdata = wd; me.gnt = 3'(1 << p); me.cyc = mem_cyc;
    mem_q.push_back(me);
    ae.port = p; ae.rdata = exp_rd; ae.cyc = ack_cyc;
    ack_q.push_back(ae);
  endtask

  task automatic drive_req(input int p, input logic v, input logic dir, input logic [16:0] addr, input logic [7:0] wd);
    case (p)
      0: begin l_req = v; l_dir = dir; l_addr = addr; l_wdata = wd; end
      1: begin d_req = v; d_dir = dir; d_addr = addr[7:0]; d_wdata = wd; end
      default: begin i_req = v; i_addr = addr[15:0]; end
    endcase
  endtask

  task automatic drop_req(input int p);
    case (p)
      0: l_req = 1'b0;
      1: d_req = 1'b0;
      default: i_req = 1'b0;
    endcase
  endtask

  // Full four-phase transaction; optionally pushes timed expectations
  task automatic do_txn(input int p, input logic dir, input logic [16:0] addr, input logic [7:0] wd,
                        input logic [16:0] exp_maddr, input logic [7:0] exp_rd, input bit push);
    int n;
    int n0;
    @(posedge clk); #1;
    drive_req(p, 1'b1, dir, addr, wd);
    n0 = cyc;
    if (push) push_exp(p, dir, exp_maddr, wd, exp_rd, n0 + 1, dir ? n0 + 2 : n0 + 3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_of(p) && n < 60);
    if (!ack_of(p)) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout port %0d: ack=0 after %0d cycles, expected 1", p, n);
    end
    @(posedge clk); #1;
    drop_req(p);
    @(negedge clk);
    check_eq("ack_hold", 32'(ack_of(p)), 1);
    @(negedge clk);
    check_eq("ack_fall", 32'(ack_of(p)), 0);
  endtask

  // Monitor: memory strobes and ack rising edges against the scoreboard
  logic [2:0] ack_prev = 3'b000;
  always @(negedge clk) begin
    logic [2:0] acks;
    mem_exp_t   me;
    ack_exp_t   ae;
    acks = {i_ack, d_ack, l_ack};
    if (rst) begin
      ack_prev = 3'b000;
    end else begin
      checks++;
      if ($countones(acks) > 1) begin
        errors++;
        $display("FAIL ack_onehot: acks=%b, expected at most one high", acks);
      end
      if (mem_en) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: mem_en=1 addr=%h, expected no access", mem_addr);
        end else begin
          me = mem_q.pop_front();
          if (mem_addr !== me.addr || mem_we !== me.we || (me.we && mem_wdata !== me.wdata) ||
              gnt !== me.gnt || (me.cyc >= 0 && cyc != me.cyc)) begin
            errors++;
            $display("FAIL mem_access: got addr=%h we=%b wd=%h gnt=%b cyc=%0d, expected addr=%h we=%b wd=%h gnt=%b cyc=%0d",
                     mem_addr, mem_we, mem_wdata, gnt, cyc, me.addr, me.we, me.wdata, me.gnt, me.cyc);
          end
        end
      end
      for (int p = 0; p < 3; p++) begin
        if (acks[p] && !ack_prev[p]) begin
          checks++;
          if (ack_q.size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected: port %0d acked, expected no ack", p);
          end else begin
            ae = ack_q.pop_front();
            $display("ack port %0d rdata %02h cycle %0d", p, rdata_of(p), cyc);
            if (ae.port != p || rdata_of(p) !== ae.rdata || (ae.cyc >= 0 && cyc != ae.cyc)) begin
              errors++;
              $display("FAIL ack: got port=%0d rdata=%h cyc=%0d, expected port=%0d rdata=%h cyc=%0d",
                       p, rdata_of(p), cyc, ae.port, ae.rdata, ae.cyc);
            end
          end
        end
      end
      ack_prev = acks;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int men_c;
    int ack_c;
    logic [16:0] men_a;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // All three request together from reset: loader, data, fetch, loader
    push_exp(0, 1'b0, 17'h1ABCD, 8'h00, 8'h77, -1, -1);
    push_exp(1, 1'b0, 17'h10040, 8'h00, 8'hC4, -1, -1);
    push_exp(2, 1'b0, 17'h00100, 8'h00, 8'h91, -1, -1);
    push_exp(0, 1'b0, 17'h1ABCE, 8'h00, 8'h5A, -1, -1);
    fork
      begin
        do_txn(0, 1'b0, 17'h1ABCD, 8'h00, 17'h0, 8'h0, 1'b0);
        do_txn(0, 1'b0, 17'h1ABCE, 8'h00, 17'h0, 8'h0, 1'b0);
      end
      do_txn(1, 1'b0, 17'h00040, 8'h00, 17'h0, 8'h0, 1'b0);
      do_txn(2, 1'b0, 17'h00100, 8'h00, 17'h0, 8'h0, 1'b0);
    join

    // Lone fetch, ack at N+3
    do_txn(2, 1'b0, 17'h00012, 8'h00, 17'h00012, 8'h2B, 1'b1);
    // Data write (ack at N+2, rdata unchanged), then read back
    do_txn(1, 1'b1, 17'h00005, 8'hA5, 17'h10005, 8'hC4, 1'b1);
    do_txn(1, 1'b0, 17'h00005, 8'h00, 17'h10005, 8'hA5, 1'b1);
    // Loader write into fetch space, fetch reads it back
    do_txn(0, 1'b1, 17'h00033, 8'h5E, 17'h00033, 8'h5A, 1'b1);
    do_txn(2, 1'b0, 17'h00033, 8'h00, 17'h00033, 8'h5E, 1'b1);

    // Data read whose requester drops req during WAIT: no ack, rdata updated
    @(posedge clk); #1;
    d_req = 1'b1; d_dir = 1'b0; d_addr = 8'h07;
    n0 = cyc;
    begin
      mem_exp_t me;
      me.addr = 17'h10007; me.we = 1'b0; me.wdata = 8'h00; me.gnt = 3'b010; me.cyc = n0 + 1;
      mem_q.push_back(me);
    end
    @(posedge clk);
    @(posedge clk); #1;
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("drop_d_rdata", 32'(d_rdata), 32'h19);
    check_eq("drop_gnt_idle", 32'(gnt), 0);
    check_eq("drop_d_ack", 32'(d_ack), 0);
    do_txn(2, 1'b0, 17'h00012, 8'h00, 17'h00012, 8'h2B, 1'b1);

    // Reset during WAIT of a loader read
    @(posedge clk); #1;
    l_req = 1'b1; l_dir = 1'b0; l_addr = 17'h1ABCD;
    n0 = cyc;
    begin
      mem_exp_t me;
      me.addr = 17'h1ABCD; me.we = 1'b0; me.wdata = 8'h00; me.gnt = 3'b001; me.cyc = n0 + 1;
      mem_q.push_back(me);
    end
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    l_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // After reset loader and fetch together: loader wins (last=2)
    push_exp(0, 1'b0, 17'h1ABCE, 8'h00, 8'h5A, -1, -1);
    push_exp(2, 1'b0, 17'h00012, 8'h00, 8'h2B, -1, -1);
    fork
      do_txn(0, 1'b0, 17'h1ABCE, 8'h00, 17'h0, 8'h0, 1'b0);
      do_txn(2, 1'b0, 17'h00012, 8'h00, 17'h0, 8'h0, 1'b0);
    join

    // After reset with loader idle, a lone fetch is granted immediately
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_txn(2, 1'b0, 17'h00100, 8'h00, 17'h00100, 8'h91, 1'b1);

    // mem_latency=4: strobe at N+1, ack at N+6
    @(posedge clk); #1;
    x_i_req = 1'b1; x_i_addr = 16'h0100;
    n0 = cyc; men_c = -1; ack_c = -1; men_a = '0;
    for (int k = 0; k < 20 && ack_c < 0; k++) begin
      @(negedge clk);
      if (x_mem_en) begin
        men_c = cyc;
        men_a = x_mem_addr;
      end
      if (x_i_ack) ack_c = cyc;
    end
    check_eq("lat4_mem_en_cycle", 32'(men_c), 32'(n0 + 1));
    check_eq("lat4_mem_addr", 32'(men_a), 32'h00100);
    check_eq("lat4_ack_cycle", 32'(ack_c), 32'(n0 + 6));
    check_eq("lat4_rdata", 32'(x_i_rdata), 32'h91);
    $display("lat4 fetch rdata %02h ack cycle %0d", x_i_rdata, ack_c);
    @(posedge clk); #1;
    x_i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("lat4_ack_fall", 32'(x_i_ack), 0);

    repeat (2) @(negedge clk);
    check_eq("mem_q_empty", 32'(mem_q.size()), 0);
    check_eq("ack_q_empty", 32'(ack_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
